// File: rtl/reset_stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// reset_stage_sequencer_if
//
// Bundles the control and status signals of the staged reset sequencer.
// The clock and the asynchronous reset are not part of this interface; they
// stay plain ports on the sequencer.
//
// Signals:
//   SOFT_RESET_REQ  level request to restart the whole release sequence
//   STAGE_ACK       per-stage ready, bit k belongs to stage k
//   STAGE_RESET     per-stage reset, active high, stage 0 released first
//   ALL_RELEASED    every stage released and acknowledged
//   FAULT           sticky acknowledge-timeout flag
//   FAULT_STAGE     index of the stage that timed out
//
// Modports:
//   master  the system side: drives requests/acks, observes the resets
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface reset_stage_sequencer_if #(
    parameter int NUM_STAGES = 4
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic                  SOFT_RESET_REQ;
    logic [NUM_STAGES-1:0] STAGE_ACK;
    logic [NUM_STAGES-1:0] STAGE_RESET;
    logic                  ALL_RELEASED;
    logic                  FAULT;
    logic [IDX_W-1:0]      FAULT_STAGE;

    modport master (
        output SOFT_RESET_REQ,
        output STAGE_ACK,
        input  STAGE_RESET,
        input  ALL_RELEASED,
        input  FAULT,
        input  FAULT_STAGE
    );

    modport slave (
        input  SOFT_RESET_REQ,
        input  STAGE_ACK,
        output STAGE_RESET,
        output ALL_RELEASED,
        output FAULT,
        output FAULT_STAGE
    );

endinterface

// File: rtl/reset_stage_sequencer.sv
// ---------------------------------------------------------------------------
// reset_stage_sequencer
//
// Releases a set of per-subsystem resets one at a time, stage 0 first.
// Every release is preceded by a settle delay of D ticks, and the next stage
// only starts its delay once the current stage has acknowledged.  A stage
// that does not acknowledge within T ticks of its release raises a sticky
// fault, re-asserts every stage and parks the sequencer until a soft-reset
// request restarts everything.
//
// Parameters:
//   REF_CLK_RATE_HZ  REF_CLK frequency in Hz
//   NUM_STAGES       number of sequenced reset outputs (1..16)
//   STAGE_DELAY_NS   settle delay before each release
//   ACK_TIMEOUT_NS   acknowledge timeout measured from a stage's release
//
// Ports:
//   REF_CLK       system clock, all logic on its rising edge
//   sync_reset_n  asynchronous, active-low reset
//   seq_bus       reset_stage_sequencer_if.slave:
//                   SOFT_RESET_REQ (in), STAGE_ACK (in),
//                   STAGE_RESET, ALL_RELEASED, FAULT, FAULT_STAGE (out)
//
// All outputs come straight from flops; nothing on the bus inputs reaches
// an output without passing through a register.
// ---------------------------------------------------------------------------
module reset_stage_sequencer #(
    parameter int REF_CLK_RATE_HZ = 50000000,
    parameter int NUM_STAGES      = 4,
    parameter int STAGE_DELAY_NS  = 1000,
    parameter int ACK_TIMEOUT_NS  = 100000
) (
    input  logic                  REF_CLK,
    input  logic                  sync_reset_n,
    reset_stage_sequencer_if.slave seq_bus
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    // Tick counts are worked out in 64-bit so that large clock rates times
    // long delays cannot overflow before the division; both are clamped to
    // at least one tick.
    localparam longint D_RAW = (longint'(STAGE_DELAY_NS) * longint'(REF_CLK_RATE_HZ))
                               / 64'sd1000000000;
    localparam longint T_RAW = (longint'(ACK_TIMEOUT_NS) * longint'(REF_CLK_RATE_HZ))
                               / 64'sd1000000000;
    localparam longint D_TICKS = (D_RAW < 64'sd1) ? 64'sd1 : D_RAW;
    localparam longint T_TICKS = (T_RAW < 64'sd1) ? 64'sd1 : T_RAW;

    // One counter serves both the settle delay and the ack timeout, so it
    // only has to hold the larger of the two reload values.
    localparam longint MAX_TICKS = (D_TICKS > T_TICKS) ? D_TICKS : T_TICKS;
    localparam int     CNT_W     = (MAX_TICKS > 64'sd1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(D_TICKS - 64'sd1);
    localparam logic [CNT_W-1:0] T_LOAD = CNT_W'(T_TICKS - 64'sd1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_RUN      = 2'd2,
        ST_FAULT    = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic [NUM_STAGES-1:0] stage_reset_q;
    logic [NUM_STAGES-1:0] stage_reset_d;
    logic                  all_released_q;
    logic                  all_released_d;
    logic                  fault_q;
    logic                  fault_d;
    logic [IDX_W-1:0]      fault_stage_q;
    logic [IDX_W-1:0]      fault_stage_d;

    logic                  soft_req;
    logic                  cnt_zero;
    logic                  ack_hit;
    logic                  last_stage;

    assign soft_req   = seq_bus.SOFT_RESET_REQ;
    assign cnt_zero   = (cnt_q == '0);
    assign ack_hit    = seq_bus.STAGE_ACK[idx_q];
    assign last_stage = (idx_q == LAST_IDX);

    // -----------------------------------------------------------------------
    // State register.  Also holds the stage index, the shared counter and
    // the registered outputs, so every output is a flop.
    // -----------------------------------------------------------------------
    always_ff @(posedge REF_CLK or negedge sync_reset_n) begin
        if (!sync_reset_n) begin
            state_q        <= ST_HOLD;
            idx_q          <= '0;
            cnt_q          <= D_LOAD;
            stage_reset_q  <= '1;
            all_released_q <= 1'b0;
            fault_q        <= 1'b0;
            fault_stage_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            stage_reset_q  <= stage_reset_d;
            all_released_q <= all_released_d;
            fault_q        <= fault_d;
            fault_stage_q  <= fault_stage_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic: state, stage index and counter.
    // A soft-reset request overrides everything and keeps reloading the
    // settle delay, so the first release always comes D edges after the
    // request is first seen low.  The counter only decrements while it is
    // nonzero, so it never wraps.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (soft_req) begin
            state_d = ST_HOLD;
            idx_d   = '0;
            cnt_d   = D_LOAD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_zero) begin
                        state_d = ST_WAIT_ACK;
                        cnt_d   = T_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                // An ack on the same edge as the timeout still counts as an
                // ack, which is why it is tested before the counter.
                ST_WAIT_ACK: begin
                    if (ack_hit) begin
                        if (last_stage) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_HOLD;
                            idx_d   = idx_q + IDX_W'(1);
                            cnt_d   = D_LOAD;
                        end
                    end else if (cnt_zero) begin
                        state_d = ST_FAULT;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end

                // RUN ignores acks entirely and FAULT waits for a soft reset.
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: next values of the registered outputs.  Only the stage
    // under the index is ever released, which keeps the released stages a
    // contiguous block starting at stage 0.
    // -----------------------------------------------------------------------
    always_comb begin
        stage_reset_d  = stage_reset_q;
        all_released_d = all_released_q;
        fault_d        = fault_q;
        fault_stage_d  = fault_stage_q;

        if (soft_req) begin
            stage_reset_d  = '1;
            all_released_d = 1'b0;
            fault_d        = 1'b0;
            fault_stage_d  = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_zero) begin
                        stage_reset_d[idx_q] = 1'b0;
                    end
                end

                ST_WAIT_ACK: begin
                    if (ack_hit) begin
                        if (last_stage) begin
                            all_released_d = 1'b1;
                        end
                    end else if (cnt_zero) begin
                        stage_reset_d = '1;
                        fault_d       = 1'b1;
                        fault_stage_d = idx_q;
                    end
                end

                default: begin
                    stage_reset_d = stage_reset_q;
                end
            endcase
        end
    end

    assign seq_bus.STAGE_RESET  = stage_reset_q;
    assign seq_bus.ALL_RELEASED = all_released_q;
    assign seq_bus.FAULT        = fault_q;
    assign seq_bus.FAULT_STAGE  = fault_stage_q;

    // -----------------------------------------------------------------------
    // Structural invariants of the reset vector.
    // Released stages form a block from stage 0 upward: the inverted vector
    // must look like 0..01..1, i.e. adding one to it leaves no common bits.
    // -----------------------------------------------------------------------
    logic [NUM_STAGES-1:0] released_mask;
    assign released_mask = ~stage_reset_q;

    a_release_order : assert property (
        @(posedge REF_CLK) disable iff (!sync_reset_n)
        (released_mask & (released_mask + NUM_STAGES'(1))) == '0
    );

    a_one_release_per_edge : assert property (
        @(posedge REF_CLK) disable iff (!sync_reset_n)
        $countones($past(stage_reset_q) & ~stage_reset_q) <= 1
    );

    a_all_released_means_clear : assert property (
        @(posedge REF_CLK) disable iff (!sync_reset_n)
        all_released_q |-> (stage_reset_q == '0)
    );

    a_fault_means_held : assert property (
        @(posedge REF_CLK) disable iff (!sync_reset_n)
        fault_q |-> (stage_reset_q == '1)
    );

endmodule

// File: tb/tb_reset_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_stage_sequencer
//
// Scoreboard bench for reset_stage_sequencer with NUM_STAGES=3, 50 MHz,
// D=5 and T=20.  For each release sequence a timeline model works out, from
// the release/ack/timeout rules, every edge on which an output must change
// and queues those changes.  A monitor samples the outputs on each falling
// edge; whenever they change it pops the next expected change and compares
// the edge number and all output values.
// ---------------------------------------------------------------------------
module tb_reset_stage_sequencer;

    localparam int N     = 3;
    localparam int IDX_W = 2;
    localparam int D     = 5;
    localparam int T     = 20;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int             edge_no;
        logic [N-1:0]   sr;
        logic           ar;
        logic           f;
        logic [IDX_W-1:0] fs;
    } obs_t;

    logic REF_CLK      = 1'b0;
    logic sync_reset_n = 1'b1;

    reset_stage_sequencer_if #(.NUM_STAGES(N)) seq_bus ();

    reset_stage_sequencer #(
        .REF_CLK_RATE_HZ (50000000),
        .NUM_STAGES      (N),
        .STAGE_DELAY_NS  (100),
        .ACK_TIMEOUT_NS  (400)
    ) dut (
        .REF_CLK      (REF_CLK),
        .sync_reset_n (sync_reset_n),
        .seq_bus      (seq_bus)
    );

    always #5 REF_CLK = ~REF_CLK;

    int   cyc          = 0;
    int   origin       = 0;
    int   ack_from [N];
    obs_t exp_q [$];
    obs_t last_exp;
    obs_t last_popped;
    int   tests_run    = 0;
    int   tests_failed = 0;

    initial begin
        forever begin
            @(posedge REF_CLK);
            cyc = cyc + 1;
        end
    end

    function automatic obs_t mkObs(input int e, input logic [N-1:0] sr, input logic ar,
                                   input logic f, input logic [IDX_W-1:0] fs);
        obs_t o;
        o.edge_no = e;
        o.sr      = sr;
        o.ar      = ar;
        o.f       = f;
        o.fs      = fs;
        return o;
    endfunction

    function automatic bit sameVals(input obs_t a, input obs_t b);
        return (a.sr === b.sr) && (a.ar === b.ar) && (a.f === b.f) && (a.fs === b.fs);
    endfunction

    function automatic obs_t sampleObs();
        return mkObs(cyc, seq_bus.STAGE_RESET, seq_bus.ALL_RELEASED,
                     seq_bus.FAULT, seq_bus.FAULT_STAGE);
    endfunction

    task automatic checkOutput(input string name, input obs_t e, input obs_t a);
        tests_run = tests_run + 1;
        if (!(a.edge_no == e.edge_no && sameVals(a, e))) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got edge %0d sr=%b ar=%b f=%b fs=%0d, required edge %0d sr=%b ar=%b f=%b fs=%0d",
                     name, a.edge_no, a.sr, a.ar, a.f, a.fs,
                     e.edge_no, e.sr, e.ar, e.f, e.fs);
        end
    endtask

    // Only real changes go into the queue, since the monitor only wakes up
    // on a change.
    task automatic pushExpected(input obs_t e);
        if (!sameVals(e, last_exp)) begin
            exp_q.push_back(e);
            last_exp = e;
        end
    endtask

    // Drops planned changes that an interrupting reset makes impossible.
    task automatic truncateFrom(input int edge_no);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].edge_no >= edge_no)
            void'(exp_q.pop_back());
        last_exp = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : last_popped;
    endtask

    // Timeline model.  off[k] places stage k's ack rise relative to that
    // stage's release edge (<=0 means already high, NEVER means never).
    // Edges are relative to origin: edge 1 is origin+1.
    task automatic planPhase(input int off [N], output int end_rel);
        logic [N-1:0] sr;
        int rel;
        int acc;
        sr      = '1;
        rel     = D;
        end_rel = 0;
        for (int k = 0; k < N; k++) ack_from[k] = NEVER;
        for (int k = 0; k < N; k++) begin
            sr[k] = 1'b0;
            pushExpected(mkObs(origin + rel, sr, 1'b0, 1'b0, '0));
            ack_from[k] = (off[k] == NEVER) ? NEVER : rel + off[k];
            if (ack_from[k] == NEVER) acc = NEVER;
            else acc = (ack_from[k] > rel + 1) ? ack_from[k] : rel + 1;
            if (acc > rel + T) begin
                pushExpected(mkObs(origin + rel + T, '1, 1'b0, 1'b1, IDX_W'(k)));
                end_rel = rel + T;
                break;
            end
            if (k == N - 1) begin
                pushExpected(mkObs(origin + acc, '0, 1'b1, 1'b0, '0));
                end_rel = acc;
            end else begin
                rel = acc + D;
            end
        end
    endtask

    task automatic driveAcks();
        int rel_now;
        rel_now = cyc + 1 - origin;
        for (int k = 0; k < N; k++)
            seq_bus.STAGE_ACK[k] = (ack_from[k] != NEVER) && (rel_now >= ack_from[k]);
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(negedge REF_CLK);
            driveAcks();
        end
    endtask

    task automatic runToRel(input int target);
        while (cyc - origin < target) applyStimulus(1);
    endtask

    task automatic startPhase(input int off [N], output int end_rel);
        planPhase(off, end_rel);
        driveAcks();
    endtask

    // Request is sampled high on edges s .. s+hold-1; the next edge is the
    // first one that sees it low and becomes edge 1 of the new sequence.
    task automatic softReset(input int hold);
        int s;
        @(negedge REF_CLK);
        seq_bus.SOFT_RESET_REQ = 1'b1;
        s = cyc + 1;
        truncateFrom(s);
        pushExpected(mkObs(s, '1, 1'b0, 1'b0, '0));
        applyStimulus(hold);
        seq_bus.SOFT_RESET_REQ = 1'b0;
        origin = cyc;
    endtask

    // Asserted between edges; the outputs must already be at their reset
    // values before the next clock edge.
    task automatic asyncReset(input int hold);
        @(posedge REF_CLK);
        #2;
        sync_reset_n = 1'b0;
        truncateFrom(cyc + 1);
        pushExpected(mkObs(cyc, '1, 1'b0, 1'b0, '0));
        #1;
        checkOutput("async_reset_now", mkObs(cyc, '1, 1'b0, 1'b0, '0), sampleObs());
        repeat (hold) @(posedge REF_CLK);
        #2;
        sync_reset_n = 1'b1;
        origin = cyc;
    endtask

    // Monitor: compares every output change against the next queued change.
    initial begin
        obs_t cur;
        obs_t prev;
        obs_t e;
        bit   have_prev;
        have_prev = 1'b0;
        forever begin
            @(negedge REF_CLK);
            cur = sampleObs();
            if (!have_prev) begin
                checkOutput("reset_state", mkObs(cyc, '1, 1'b0, 1'b0, '0), cur);
                have_prev = 1'b1;
            end else if (!sameVals(cur, prev)) begin
                if (exp_q.size() == 0) begin
                    tests_run    = tests_run + 1;
                    tests_failed = tests_failed + 1;
                    $display("[TB] FAIL unexpected_change: got edge %0d sr=%b ar=%b f=%b fs=%0d, required no output change",
                             cur.edge_no, cur.sr, cur.ar, cur.f, cur.fs);
                end else begin
                    e = exp_q.pop_front();
                    last_popped = e;
                    checkOutput("output_change", e, cur);
                end
            end
            prev = cur;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int offs [N];
        int end_rel;

        seq_bus.SOFT_RESET_REQ = 1'b0;
        seq_bus.STAGE_ACK      = '0;
        for (int k = 0; k < N; k++) ack_from[k] = NEVER;
        last_exp    = mkObs(0, '1, 1'b0, 1'b0, '0);
        last_popped = last_exp;

        #1 sync_reset_n = 1'b0;
        repeat (3) @(posedge REF_CLK);
        #2 sync_reset_n = 1'b1;
        origin = cyc;

        // Acks tied high: releases at 5, 11, 17 and ALL_RELEASED at 18.
        offs = '{-100, -100, -100};
        startPhase(offs, end_rel);
        runToRel(end_rel + 3);

        // Acks dropped in RUN: nothing may change for 50 cycles.
        for (int k = 0; k < N; k++) ack_from[k] = NEVER;
        applyStimulus(50);

        // Soft reset from RUN, then stage 1 never acks: fault at edge 31.
        softReset(3);
        offs = '{-100, NEVER, -100};
        startPhase(offs, end_rel);
        runToRel(end_rel + 100);

        // Soft reset from FAULT, then stage 1 acks exactly on its timeout edge.
        softReset(3);
        offs = '{-100, T, -100};
        startPhase(offs, end_rel);
        runToRel(end_rel + 5);

        // Async reset while stage 1 is waiting for its ack.
        softReset(2);
        offs = '{-100, NEVER, -100};
        startPhase(offs, end_rel);
        runToRel(13);
        asyncReset(2);
        offs = '{-100, -100, -100};
        startPhase(offs, end_rel);
        runToRel(end_rel + 3);

        // Randomized ack timing, including timeout boundaries and restarts.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 3) == 0) asyncReset(int'($urandom_range(1, 3)));
            else                           softReset(int'($urandom_range(1, 3)));
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) offs[k] = NEVER;
                else                           offs[k] = int'($urandom_range(0, T + 5)) - 3;
            end
            startPhase(offs, end_rel);
            runToRel(end_rel + int'($urandom_range(2, 10)));
        end

        applyStimulus(2);
        tests_run = tests_run + 1;
        if (exp_q.size() != 0) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL pending_changes: got %0d expected output changes never seen, required 0",
                     exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
